morra_cinese_param: RTL
=======================

# morra_cinese_param

Parametrised successor of the two-player Morra Cinese (rock-paper-scissors) referee. It scores a match of 2-player rounds with a configurable move set (3 or 5 moves) and a configurable minimum round count and winning lead. It also provides an optional no-repeat rule, per-player score counters, and a DONE flag. It sits between the player-input sampling logic and the display/score-board logic, with one round judged per clock.

## Interface
- NUM_MOVES, 3, number of legal moves; odd, 3 or 5; legal codes 1..NUM_MOVES, code 0 = no move
- MIN_ROUNDS, 4, valid rounds that must be played before a lead can end the match
- LEAD_TO_WIN, 2, score lead that ends the match once MIN_ROUNDS is reached; >=1
- NO_REPEAT, 1, 1 = the previous round's winner may not replay its winning move
- Derived: MOVE_W = clog2(NUM_MOVES+1); CNT_W = 2*MOVE_W+1; MIN_ROUNDS <= 2^(2*MOVE_W) required
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- START  in  1  start/restart match; samples configuration from P1,P2
- P1  in  MOVE_W  player 1 move
- P2  in  MOVE_W  player 2 move
- ROUND  out  2  last round result: 00 void/none, 01 P1, 10 P2, 11 draw
- GAME  out  2  match result: 00 in progress/none, 01 P1, 10 P2, 11 draw
- DONE  out  1  match finished, GAME valid
- SCORE1, SCORE2  out  CNT_W  rounds won per player
- PLAYED  out  CNT_W  valid rounds played (draws included)

## Operation
- States: IDLE, PLAY, OVER. Reset → IDLE; all outputs 0, internal MAX/prev-winner/prev-move 0.
- START=1 (any state, highest priority): next edge → PLAY. MAX <= {P1,P2} + MIN_ROUNDS (CNT_W bits, no overflow by construction). Scores, PLAYED, ROUND, GAME, DONE, prev-winner and prev-move all cleared.
- IDLE / OVER with START=0: moves ignored. ROUND <= 00. GAME, DONE, scores and PLAYED hold.
- PLAY with START=0: each cycle is one round attempt on sampled P1,P2.
  - Void if either move is 0 or >NUM_MOVES, or if NO_REPEAT and (prev-winner=P1 and P1==prev-move, or prev-winner=P2 and P2==prev-move). Void: ROUND <= 00, nothing else changes.
  - Otherwise d = (P1 - P2) mod NUM_MOVES. d=0 → draw. d in 1..(NUM_MOVES-1)/2 → P1 wins. Else → P2 wins. For NUM_MOVES=3: 1 rock, 2 paper, 3 scissors.
  - P1 win: SCORE1+1, prev-winner=P1, prev-move=P1, ROUND 01. P2 win is symmetric (ROUND 10). Draw: prev-winner/prev-move cleared, ROUND 11. PLAYED+1 on every valid round.
  - End check on the updated values, same edge: end if PLAYED'==MAX, or (PLAYED'>=MIN_ROUNDS and |SCORE1'-SCORE2'|>=LEAD_TO_WIN). On end: → OVER, DONE <= 1, GAME <= 01 if SCORE1'>SCORE2', 10 if less, 11 if equal.
- Lead is compared as a signed difference of CNT_W+1 bits. Scores never wrap, because PLAYED <= MAX < 2^CNT_W.

## Timing
- All outputs registered. A round sampled on edge k is reflected on ROUND/SCORE/PLAYED after edge k; GAME/DONE update on the same edge as the deciding round.
- First round is judged on the edge after the START edge. P1,P2 in the START cycle are configuration only.
- START held high: stays in restart (cleared) each cycle, with MAX re-sampled each cycle.
- START in PLAY mid-match: the round in that cycle is discarded, not scored.
- rst_n low at any time: immediate clear to reset values regardless of clk.
- ROUND is a one-cycle-per-round value, overwritten every PLAY cycle. It is 00 in IDLE/OVER.

## Test plan
- Reset mid-match (rst_n low between edges) → all outputs 0 immediately, state IDLE, later moves ignored until START.
- START with P1=00,P2=00 (MAX=4); four rounds (01,01) → ROUND=11 each, PLAYED 1..4; after 4th edge GAME=11, DONE=1, SCORE1=SCORE2=0.
- START with P1=11,P2=11 (MAX=19); (01,11) → ROUND 01; (01,11) → ROUND 00 (no-repeat), PLAYED=1; (10,01) → 01, lead 2 but PLAYED=2 <4, continue; (11,11) ×2 → PLAYED=4, GAME=01, DONE=1; further moves → ROUND 00, scores hold.
- Void inputs in PLAY: (00,10) and (10,00) → ROUND 00, PLAYED/scores unchanged; same with NO_REPEAT=0 and a repeated winning move → scored normally.
- START asserted in PLAY after 3 rounds, with (01,01) → cleared outputs next edge, MAX=5+4=9, the round in the START cycle is not counted.
- NUM_MOVES=5 instance (MOVE_W=3): (101,100) → ROUND 01; (100,001) → ROUND 10; (110,001) → ROUND 00 (illegal code 6).

Source files
------------

// File: rtl/morra_cinese_param.sv
`default_nettype none
// ============================================================================
// Module   : morra_cinese_param
// Purpose  : Parametrised rock-paper-scissors match referee, one round per clock.
// Revision : 1.0
// ============================================================================
module morra_cinese_param #(
  parameter int NUM_MOVES   = 3,
  parameter int MIN_ROUNDS  = 4,
  parameter int LEAD_TO_WIN = 2,
  parameter int NO_REPEAT   = 1,
  localparam int MOVE_W     = $clog2(NUM_MOVES + 1),
  localparam int CNT_W      = 2 * MOVE_W + 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [MOVE_W-1:0] p1_i,
  input  logic [MOVE_W-1:0] p2_i,
  output logic [1:0]        round_o,
  output logic [1:0]        game_o,
  output logic              done_o,
  output logic [CNT_W-1:0]  score1_o,
  output logic [CNT_W-1:0]  score2_o,
  output logic [CNT_W-1:0]  played_o
);

  localparam logic [MOVE_W-1:0]     c_num  = MOVE_W'(NUM_MOVES);
  localparam logic [MOVE_W:0]       c_half = (MOVE_W+1)'((NUM_MOVES - 1) / 2);
  localparam logic [CNT_W-1:0]      c_min  = CNT_W'(MIN_ROUNDS);
  localparam logic signed [CNT_W:0] c_lead = (CNT_W+1)'(LEAD_TO_WIN);

  localparam logic [1:0] c_none = 2'b00;
  localparam logic [1:0] c_p1   = 2'b01;
  localparam logic [1:0] c_p2   = 2'b10;
  localparam logic [1:0] c_draw = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_OVER = 2'd2
  } state_t;

  state_t             state_q;
  logic [CNT_W-1:0]   max_q;
  logic [CNT_W-1:0]   score1_q, score2_q, played_q;
  logic [1:0]         round_q, game_q;
  logic               done_q;
  logic [1:0]         pw_q;
  logic [MOVE_W-1:0]  pm_q;

  logic               w_legal, w_blocked, w_valid;
  logic [MOVE_W:0]    w_diff;
  logic               w_p1win, w_p2win, w_end;
  logic [CNT_W-1:0]   score1_d, score2_d, played_d;
  logic signed [CNT_W:0] w_lead;
  logic [1:0]         w_result, w_round;

  always_comb begin
    w_legal   = (p1_i != '0) && (p1_i <= c_num) && (p2_i != '0) && (p2_i <= c_num);
    w_blocked = (NO_REPEAT != 0) &&
                (((pw_q == c_p1) && (p1_i == pm_q)) || ((pw_q == c_p2) && (p2_i == pm_q)));
    w_valid   = w_legal && !w_blocked;
    // (P1 - P2) mod NUM_MOVES without a divider: add NUM_MOVES back on underflow.
    if (p1_i >= p2_i) w_diff = {1'b0, p1_i} - {1'b0, p2_i};
    else              w_diff = {1'b0, p1_i} + {1'b0, c_num} - {1'b0, p2_i};
    w_p1win  = (w_diff != '0) && (w_diff <= c_half);
    w_p2win  = (w_diff > c_half);
    score1_d = score1_q + CNT_W'(w_p1win);
    score2_d = score2_q + CNT_W'(w_p2win);
    played_d = played_q + CNT_W'(1);
    w_lead   = $signed({1'b0, score1_d}) - $signed({1'b0, score2_d});
    w_end    = (played_d == max_q) ||
               ((played_d >= c_min) && ((w_lead >= c_lead) || (w_lead <= -c_lead)));
    if (score1_d > score2_d)      w_result = c_p1;
    else if (score1_d < score2_d) w_result = c_p2;
    else                          w_result = c_draw;
    if (w_p1win)      w_round = c_p1;
    else if (w_p2win) w_round = c_p2;
    else              w_round = c_draw;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      max_q    <= '0;
      score1_q <= '0;
      score2_q <= '0;
      played_q <= '0;
      round_q  <= c_none;
      game_q   <= c_none;
      done_q   <= 1'b0;
      pw_q     <= c_none;
      pm_q     <= '0;
    end else if (start_i) begin
      state_q  <= S_PLAY;
      max_q    <= CNT_W'({p1_i, p2_i}) + c_min;
      score1_q <= '0;
      score2_q <= '0;
      played_q <= '0;
      round_q  <= c_none;
      game_q   <= c_none;
      done_q   <= 1'b0;
      pw_q     <= c_none;
      pm_q     <= '0;
    end else if (state_q == S_PLAY) begin
      if (w_valid) begin
        score1_q <= score1_d;
        score2_q <= score2_d;
        played_q <= played_d;
        round_q  <= w_round;
        if (w_p1win) begin
          pw_q <= c_p1;
          pm_q <= p1_i;
        end else if (w_p2win) begin
          pw_q <= c_p2;
          pm_q <= p2_i;
        end else begin
          pw_q <= c_none;
          pm_q <= '0;
        end
        if (w_end) begin
          state_q <= S_OVER;
          done_q  <= 1'b1;
          game_q  <= w_result;
        end
      end else begin
        round_q <= c_none;
      end
    end else begin
      round_q <= c_none;
    end
  end

  assign round_o  = round_q;
  assign game_o   = game_q;
  assign done_o   = done_q;
  assign score1_o = score1_q;
  assign score2_o = score2_q;
  assign played_o = played_q;

endmodule
`default_nettype wire
